// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - framed byte-stream loader for the RV32I instruction memory
// Holds core_rst high until a length-checked, XOR-verified image has been written.
module imem_boot_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_waddr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam int          CW    = ADDR_WIDTH + 1;
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_buf_q, word_buf_d;
  logic [7:0]            csum_q, csum_d;
  logic [CW-1:0]         words_loaded_d;
  logic [CW-1:0]         words_next;
  logic [15:0]           len_full;
  logic                  imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_waddr_d;
  logic [31:0]           imem_wdata_d;
  logic                  accept;

  assign accept     = in_valid && in_ready;
  assign words_next = words_loaded + CW'(1);
  assign len_full   = {in_data, len_q[7:0]};

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    byte_idx_d     = byte_idx_q;
    word_buf_d     = word_buf_q;
    csum_d         = csum_q;
    words_loaded_d = words_loaded;
    imem_we_d      = 1'b0;
    imem_waddr_d   = imem_waddr;
    imem_wdata_d   = imem_wdata;

    case (state_q)
      S_IDLE: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_d        = S_LEN_LO;
          byte_idx_d     = 2'd0;
          csum_d         = 8'h00;
          words_loaded_d = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = in_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          if ({1'b0, len_full} > DEPTH)
            state_d = S_ERROR;
          else if (len_full == 16'd0)
            state_d = S_CHECK;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_buf_d[7:0]   = in_data;
            2'd1: word_buf_d[15:8]  = in_data;
            2'd2: word_buf_d[23:16] = in_data;
            default: begin
              imem_we_d      = 1'b1;
              imem_waddr_d   = words_loaded[ADDR_WIDTH-1:0];
              imem_wdata_d   = {in_data, word_buf_q};
              words_loaded_d = words_next;
              if (17'(words_next) == {1'b0, len_q})
                state_d = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        if (accept)
          state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          state_d        = S_IDLE;
          csum_d         = 8'h00;
          words_loaded_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they switch on the
  // same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      csum_q       <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_waddr   <= '0;
      imem_wdata   <= '0;
      in_ready     <= 1'b1;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      csum_q       <= csum_d;
      words_loaded <= words_loaded_d;
      imem_we      <= imem_we_d;
      imem_waddr   <= imem_waddr_d;
      imem_wdata   <= imem_wdata_d;
      in_ready     <= (state_d != S_DONE) && (state_d != S_ERROR);
      core_rst     <= (state_d != S_DONE);
      done         <= (state_d == S_DONE);
      error        <= (state_d == S_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - directed bench for imem_boot_loader
// Drives framed byte streams and checks writes and status against hand-computed values.
module tb_imem_boot_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          reload;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] log_addr [0:63];
  logic [31:0]   log_data [0:63];
  int            wr_count = 0;
  int            wr0;
  logic [7:0]    frame [$];

  imem_boot_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .core_rst(core_rst),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_count < 64) begin
        log_addr[wr_count] = imem_waddr;
        log_data[wr_count] = imem_wdata;
      end
      wr_count = wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: in_ready observed 0 expected 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int count, input bit gaps);
    for (int i = 0; i < count; i++)
      send(frame[i], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic settle();
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic chk_good_writes(input string tag);
    chk({tag, "_nwr"}, wr_count - wr0, 2);
    chk({tag, "_a0"}, 32'(log_addr[wr0]), 0);
    chk({tag, "_d0"}, log_data[wr0], 32'h00500093);
    chk({tag, "_a1"}, 32'(log_addr[wr0 + 1]), 1);
    chk({tag, "_d1"}, log_data[wr0 + 1], 32'h00A00113);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_core_rst"}, 32'(core_rst), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = 8'h00;
    in_valid = 1'b0;
    reload   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_core_rst", 32'(core_rst), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_words", 32'(words_loaded), 0);
    rst = 1'b0;
    @(negedge clk);

    // Good two-word frame, back to back
    frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    wr0 = wr_count;
    send_frame(11, 1'b0);
    chk("good_pre_check_done", 32'(done), 0);
    chk("good_pre_check_core_rst", 32'(core_rst), 1);
    send(frame[11], 0);
    chk_done("good");
    chk("good_words", 32'(words_loaded), 2);
    settle();
    chk_good_writes("good");
    chk("good_hold_done", 32'(done), 1);

    // Preamble junk and random valid gaps
    pulse_reload();
    chk("reload_done", 32'(done), 0);
    chk("reload_core_rst", 32'(core_rst), 1);
    chk("reload_words", 32'(words_loaded), 0);
    chk("reload_in_ready", 32'(in_ready), 1);
    wr0 = wr_count;
    send(8'h00, 1);
    send(8'hFF, 2);
    send(8'h5A, 0);
    settle();
    chk("preamble_nwr", wr_count - wr0, 0);
    send_frame(12, 1'b1);
    chk_done("gaps");
    settle();
    chk_good_writes("gaps");

    // Bad checksum, then recovery
    pulse_reload();
    frame[11] = 8'h70;
    wr0 = wr_count;
    send_frame(12, 1'b0);
    chk("badck_error", 32'(error), 1);
    chk("badck_done", 32'(done), 0);
    chk("badck_core_rst", 32'(core_rst), 1);
    chk("badck_in_ready", 32'(in_ready), 0);
    settle();
    chk_good_writes("badck");
    chk("badck_sticky", 32'(error), 1);
    pulse_reload();
    chk("err_reload_error", 32'(error), 0);
    chk("err_reload_in_ready", 32'(in_ready), 1);
    frame[11] = 8'h71;
    wr0 = wr_count;
    send_frame(12, 1'b0);
    chk_done("recover");
    settle();
    chk_good_writes("recover");

    // Length overflow N=257
    pulse_reload();
    wr0 = wr_count;
    send(8'hA5, 0);
    send(8'h01, 0);
    chk("ovf_pre_error", 32'(error), 0);
    send(8'h01, 0);
    chk("ovf_error", 32'(error), 1);
    chk("ovf_in_ready", 32'(in_ready), 0);
    settle();
    chk("ovf_nwr", wr_count - wr0, 0);

    // Empty frame, good and bad checksum
    pulse_reload();
    wr0 = wr_count;
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(4, 1'b0);
    chk_done("empty");
    chk("empty_words", 32'(words_loaded), 0);
    settle();
    chk("empty_nwr", wr_count - wr0, 0);
    pulse_reload();
    frame[3] = 8'h01;
    send_frame(4, 1'b0);
    chk("empty_bad_error", 32'(error), 1);
    chk("empty_bad_done", 32'(done), 0);
    pulse_reload();

    // Reset in mid-frame, then a full reload from scratch
    frame = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
              8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    wr0 = wr_count;
    send_frame(6, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_core_rst", 32'(core_rst), 1);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_error", 32'(error), 0);
    chk("mid_rst_we", 32'(imem_we), 0);
    chk("mid_rst_waddr", 32'(imem_waddr), 0);
    chk("mid_rst_wdata", imem_wdata, 0);
    chk("mid_rst_words", 32'(words_loaded), 0);
    chk("mid_rst_nwr", wr_count - wr0, 0);
    send_frame(12, 1'b0);
    chk_done("after_rst");
    chk("after_rst_words", 32'(words_loaded), 2);
    settle();
    chk_good_writes("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle RV32I core's instruction memory.
- Receives a byte stream over a valid/ready handshake and checks a framing header.
- Assembles little-endian 32-bit words, writes them into instruction memory through a dedicated write port, and verifies an XOR checksum.
- Holds the core in reset (core_rst) until a load completes successfully.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity DEPTH = 2**ADDR_WIDTH words
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept a byte
reload  input  1  single-cycle pulse; restarts loading from DONE or ERROR
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_waddr  output  ADDR_WIDTH  word address of write
imem_wdata  output  32  assembled instruction word
core_rst  output  1  reset to core; high unless state is DONE
done  output  1  load completed, checksum good
error  output  1  framing/length/checksum failure, sticky
words_loaded  output  ADDR_WIDTH+1  count of words written this load

Behaviour:
- Byte accepted on a rising edge where in_valid && in_ready. No action on cycles without acceptance; in_valid gaps of any length are legal.
- Reset (rst=1 at edge, any state, including mid-frame):
  - state=IDLE; in_ready=1; imem_we=0; imem_waddr=0; imem_wdata=0.
  - core_rst=1; done=0; error=0; words_loaded=0; length, byte index and checksum registers cleared.
- States and transitions:
  - IDLE: accepted byte == SYNC_BYTE -> LEN_LO. Any other byte is discarded; stay in IDLE.
  - LEN_LO: accepted byte -> N[7:0]; go to LEN_HI.
  - LEN_HI: accepted byte -> N[15:8]. Then:
    - N > DEPTH -> ERROR.
    - N == 0 -> CHECK.
    - else -> DATA.
  - DATA: bytes fill the word little-endian (byte 0 -> [7:0] ... byte 3 -> [31:24]); every data byte is XORed into the checksum.
    - On acceptance of the 4th byte of a word, at the next edge: imem_we=1 for exactly one cycle, imem_wdata=assembled word, imem_waddr=word index, words_loaded incremented.
    - Word index starts at 0 and increments by 1 per word; it never wraps, because N <= DEPTH is enforced.
    - After the 4th byte of word N-1 -> CHECK.
  - CHECK: accepted byte == running checksum -> DONE; else -> ERROR. For N=0, the expected checksum is 8'h00.
  - DONE: done=1, core_rst=0, in_ready=0. reload -> IDLE with done=0, core_rst=1, words_loaded=0, checksum cleared.
  - ERROR: error=1, core_rst=1, in_ready=0. reload -> IDLE with error=0. Otherwise ERROR holds until reload or rst.
- in_ready=1 in IDLE, LEN_LO, LEN_HI, DATA and CHECK; 0 in DONE and ERROR. in_ready is registered (decoded from state), with no combinational path from in_valid.
- done/error/core_rst change on the edge that enters or leaves DONE/ERROR. core_rst falls on the same edge that done rises.
- reload in IDLE..CHECK is ignored. rst has priority over reload.
- The final imem_we pulse of a frame precedes the checksum byte, so memory is fully written before DONE. On ERROR, words already written stay in memory; core_rst remains 1.
- Instruction memory must accept the write in the cycle imem_we=1 (single-cycle write port; no backpressure from memory).

Test Plan:
- Good load, ADDR_WIDTH=8, bytes A5 02 00 93 00 50 00 13 01 A0 00 71 -> imem_we pulses: addr0=32'h00500093, then addr1=32'h00A00113; done=1, core_rst=0, error=0, words_loaded=2, in_ready=0.
- Same frame preceded by 00 FF 5A, with random in_valid gaps -> identical writes and done=1; preamble bytes produce no writes.
- Good load with final byte 70 (bad checksum) -> two writes occur, then error=1, done=0, core_rst=1, in_ready=0. A reload pulse then the good frame -> done=1.
- Length overflow: A5 01 01 (N=257 > 256) -> error=1 on the edge after the third byte; no imem_we ever asserted.
- Empty frame A5 00 00 00 -> done=1, words_loaded=0, no writes. Frame A5 00 00 01 -> error=1.
- rst asserted after the 6th byte of the good frame -> all outputs at reset values next cycle. Full good frame afterwards -> writes restart at addr0, done=1.
